// File: rtl/integral_image_gen.sv
// integral_image_gen: streaming integral-image generator for the face-detection
// front end. Accepts one raster-order 8-bit pixel per handshake and writes the
// inclusive integral ii(x,y) to the image RAM one cycle after acceptance.
// Optional build macro SQ_SUM_EN adds ii_sq_data, the integral of p*p, for
// window-variance normalisation.
module integral_image_gen #(
  parameter int MAX_W  = 320,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       cfg_width,
  input  logic [15:0]       cfg_height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        pix_data,
  output logic              ii_we,
  output logic [ADDR_W-1:0] ii_addr,
  output logic [DATA_W-1:0] ii_data,
`ifdef SQ_SUM_EN
  output logic [2*DATA_W-1:0] ii_sq_data,
`endif
  output logic              busy,
  output logic              done
);

  localparam int XW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [15:0] MAX_W16 = 16'(MAX_W);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [15:0]       y;
  logic [XW-1:0]     w_m1;
  logic [15:0]       h_m1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] row_sum;
  logic [DATA_W-1:0] lbuf [0:MAX_W-1];

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  logic              accept;
  logic              last_px;
  logic              cfg_ok;
  logic [15:0]       cfg_w_m1;
  logic [15:0]       cfg_h_m1;
  logic [DATA_W-1:0] pix_ext;
  logic [DATA_W-1:0] rs_p0;
  logic [DATA_W-1:0] up_p0;
  logic [DATA_W-1:0] ii_p0;

  assign accept   = pix_valid && pix_ready;
  assign last_px  = (x == w_m1) && (y == h_m1);
  assign cfg_ok   = (cfg_width != 16'd0) && (cfg_width <= MAX_W16) && (cfg_height != 16'd0);
  assign cfg_w_m1 = cfg_width - 16'd1;
  assign cfg_h_m1 = cfg_height - 16'd1;
  assign pix_ext  = DATA_W'(pix_data);

  // Stage p0: row running sum plus the same column of the previous row
  always_comb begin
    rs_p0 = ((x == '0) ? '0 : row_sum) + pix_ext;
    up_p0 = (y == 16'd0) ? '0 : lbuf[x];
    ii_p0 = rs_p0 + up_p0;
  end

  // Line buffer holds the previous row's integrals; read and overwritten in the same cycle
  always_ff @(posedge clk) begin
    if (accept) lbuf[x] <= ii_p0;
  end

`ifdef SQ_SUM_EN
  localparam int SQ_W = 2 * DATA_W;

  logic [SQ_W-1:0] row_sum_sq;
  logic [SQ_W-1:0] lbuf_sq [0:MAX_W-1];
  logic [15:0]     pix_sq;
  logic [SQ_W-1:0] rs_sq_p0;
  logic [SQ_W-1:0] ii_sq_p0;
  logic [SQ_W-1:0] sq_p1;

  assign pix_sq = {8'd0, pix_data} * {8'd0, pix_data};

  // Stage p0 for the squared-pixel integral, same structure as the linear path
  always_comb begin
    rs_sq_p0 = ((x == '0) ? '0 : row_sum_sq) + SQ_W'(pix_sq);
    ii_sq_p0 = rs_sq_p0 + ((y == 16'd0) ? '0 : lbuf_sq[x]);
  end

  // Squared line buffer, previous-row integrals of p*p
  always_ff @(posedge clk) begin
    if (accept) lbuf_sq[x] <= ii_sq_p0;
  end

  // Stage p1: squared integral register, qualified by ii_we
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sum_sq <= '0;
      sq_p1      <= '0;
    end else if (accept) begin
      row_sum_sq <= rs_sq_p0;
      sq_p1      <= ii_sq_p0;
    end
  end

  assign ii_sq_data = sq_p1;
`endif

  // Frame FSM, pixel/row counters and the p1 write register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      w_m1      <= '0;
      h_m1      <= '0;
      addr      <= '0;
      row_sum   <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= addr;
        data_p1 <= ii_p0;
        row_sum <= rs_p0;
        addr    <= addr + ADDR_W'(1);
        if (x == w_m1) begin
          x <= '0;
          y <= y + 16'd1;
        end else begin
          x <= x + XW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state     <= RUN;
              w_m1      <= cfg_w_m1[XW-1:0];
              h_m1      <= cfg_h_m1;
              x         <= '0;
              y         <= '0;
              addr      <= '0;
              row_sum   <= '0;
              pix_ready <= 1'b1;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept && last_px) begin
            state     <= FLUSH;
            pix_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ii_we   = vld_p1;
  assign ii_addr = addr_p1;
  assign ii_data = data_p1;

endmodule

// File: tb/tb_integral_image_gen.sv
// Self-checking bench for integral_image_gen: directed frames from the block's
// behaviour description plus randomized frames, checked against a direct
// summation model of the inclusive integral image.
module tb_integral_image_gen;

  localparam int MAX_W   = 320;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 32;
  localparam int MAX_PIX = 2560;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       cfg_width = '0;
  logic [15:0]       cfg_height = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready;
  logic [7:0]        pix_data = '0;
  logic              ii_we;
  logic [ADDR_W-1:0] ii_addr;
  logic [DATA_W-1:0] ii_data;
`ifdef SQ_SUM_EN
  logic [2*DATA_W-1:0] ii_sq_data;
`endif
  logic              busy;
  logic              done;

  integral_image_gen #(.MAX_W(MAX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .ii_we(ii_we), .ii_addr(ii_addr), .ii_data(ii_data),
`ifdef SQ_SUM_EN
    .ii_sq_data(ii_sq_data),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_total = 0;

  logic [7:0]  pix [0:MAX_PIX-1];
  int          wq_addr[$];
  logic [63:0] wq_data[$];
  logic [63:0] wq_sq[$];
  int          wq_cyc[$];
  int          acc_cyc[$];
  int          done_q[$];
  logic        done_busy[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (ii_we) begin
      wq_addr.push_back(int'(ii_addr));
      wq_data.push_back(64'(ii_data));
`ifdef SQ_SUM_EN
      wq_sq.push_back(ii_sq_data);
`else
      wq_sq.push_back(64'd0);
`endif
      wq_cyc.push_back(cyc);
      we_total++;
    end
    if (done) begin
      done_q.push_back(cyc);
      done_busy.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Direct definition: sum of every pixel above-and-left, inclusive
  function automatic logic [63:0] ref_ii(input int x, input int y, input int w, input bit sq);
    logic [63:0] s = 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s += sq ? 64'(pix[j*w+i]) * 64'(pix[j*w+i]) : 64'(pix[j*w+i]);
    return s;
  endfunction

  // mode: 0 continuous, 1 valid toggling 1-0-1, 2 random gaps
  task automatic run_frame(input int w, input int h, input int mode, input int abort, input bit mid_start);
    int n = w * h;
    int i = 0;
    int guard = 0;
    bit ph = 1'b1;
    wq_addr.delete(); wq_data.delete(); wq_sq.delete(); wq_cyc.delete();
    acc_cyc.delete(); done_q.delete(); done_busy.delete();
    @(posedge clk); #1;
    cfg_width = 16'(w); cfg_height = 16'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (i < n && guard < 4 * n + 50) begin
      case (mode)
        0: pix_valid = 1'b1;
        1: begin pix_valid = ph; ph = ~ph; end
        default: pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      pix_data = pix[i];
      if (mid_start && i == n / 2) begin
        start = 1'b1; cfg_width = 16'(w + 1); cfg_height = 16'(h + 1);
      end
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        acc_cyc.push_back(cyc);
        i++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (abort > 0 && i == abort) return;
    end
    pix_valid = 1'b0;
    if (i < n) chk("feed_timeout", 64'(i), 64'(n));
    for (int t = 0; t < 20 && done_q.size() == 0; t++) @(negedge clk);
    if (done_q.size() == 0) chk("done_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input int w, input int h);
    int n = w * h;
    chk("wr_count", 64'(wq_addr.size()), 64'(n));
    chk("acc_count", 64'(acc_cyc.size()), 64'(n));
    for (int k = 0; k < n && k < wq_addr.size(); k++) begin
      chk("addr", 64'(wq_addr[k]), 64'(k));
      chk("data", wq_data[k], ref_ii(k % w, k / w, w, 1'b0));
`ifdef SQ_SUM_EN
      chk("sq_data", wq_sq[k], ref_ii(k % w, k / w, w, 1'b1));
`endif
      if (k < acc_cyc.size()) chk("wr_latency", 64'(wq_cyc[k]), 64'(acc_cyc[k] + 1));
    end
    chk("done_count", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0 && acc_cyc.size() == n) begin
      chk("done_latency", 64'(done_q[0]), 64'(acc_cyc[n-1] + 2));
      chk("busy_at_done", 64'(done_busy[0]), 64'd0);
    end
  endtask

  task automatic bad_start(input int w, input int h);
    int snap = we_total;
    done_q.delete();
    @(posedge clk); #1;
    cfg_width = 16'(w); cfg_height = 16'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_ready", 64'(pix_ready), 64'd0);
    repeat (4) @(negedge clk);
    chk("bad_no_write", 64'(we_total), 64'(snap));
    chk("bad_done_count", 64'(done_q.size()), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, snap;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_we", 64'(ii_we), 64'd0);
    chk("rst_addr", 64'(ii_addr), 64'd0);
    chk("rst_data", 64'(ii_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(pix_ready), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 3x3 all ones, no gaps: 1,2,3,2,4,6,3,6,9
    for (int k = 0; k < 9; k++) pix[k] = 8'd1;
    run_frame(3, 3, 0, 0, 1'b0);
    check_frame(3, 3);
    if (wq_data.size() == 9) begin
      chk("ones_d4", wq_data[4], 64'd4);
      chk("ones_d8", wq_data[8], 64'd9);
    end

    // 4x2 saturated pixels: addr 7 = 2040
    for (int k = 0; k < 8; k++) pix[k] = 8'd255;
    run_frame(4, 2, 0, 0, 1'b0);
    check_frame(4, 2);
    if (wq_data.size() == 8) chk("sat_d7", wq_data[7], 64'd2040);

    // 4x2 ramp 0..7: addr 3 = 6, addr 7 = 28
    for (int k = 0; k < 8; k++) pix[k] = 8'(k);
    run_frame(4, 2, 0, 0, 1'b0);
    check_frame(4, 2);
    if (wq_data.size() == 8) begin
      chk("ramp_d3", wq_data[3], 64'd6);
      chk("ramp_d7", wq_data[7], 64'd28);
    end

    // 3x3 ramp with valid toggling
    for (int k = 0; k < 9; k++) pix[k] = 8'(k + 1);
    run_frame(3, 3, 1, 0, 1'b0);
    check_frame(3, 3);

    // Second start mid-frame must be ignored
    run_frame(3, 3, 0, 0, 1'b1);
    check_frame(3, 3);

    // Reset after the 5th pixel, pixels still offered while idle
    run_frame(3, 3, 0, 5, 1'b0);
    snap = we_total;
    reset = 1'b1;
    pix_valid = 1'b1;
    @(negedge clk);
    chk("abort_we", 64'(ii_we), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(pix_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_idle_ready", 64'(pix_ready), 64'd0);
    chk("abort_no_write", 64'(we_total), 64'(snap));
    chk("abort_no_done", 64'(done_q.size()), 64'd0);
    pix_valid = 1'b0;
    for (int k = 0; k < 4; k++) pix[k] = 8'(k + 1);
    run_frame(2, 2, 0, 0, 1'b0);
    check_frame(2, 2);
    if (wq_data.size() == 4) chk("restart_d3", wq_data[3], 64'd10);

    // Squared-integral example: 2,3,4,5
    for (int k = 0; k < 4; k++) pix[k] = 8'(k + 2);
    run_frame(2, 2, 0, 0, 1'b0);
    check_frame(2, 2);

    // Rejected configurations
    bad_start(0, 3);
    bad_start(3, 0);
    bad_start(MAX_W + 1, 2);

    // Widest frame and single-column frame
    for (int k = 0; k < 2 * MAX_W; k++) pix[k] = 8'd255;
    run_frame(MAX_W, 2, 0, 0, 1'b0);
    check_frame(MAX_W, 2);
    for (int k = 0; k < 3; k++) pix[k] = 8'($urandom_range(0, 255));
    run_frame(1, 3, 2, 0, 1'b0);
    check_frame(1, 3);

    // Randomized frames
    for (int r = 0; r < 20; r++) begin
      w = $urandom_range(1, 16);
      h = $urandom_range(1, 6);
      for (int k = 0; k < w * h; k++) pix[k] = 8'($urandom_range(0, 255));
      run_frame(w, h, $urandom_range(0, 2), 0, 1'b0);
      check_frame(w, h);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
